// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin unit values, payout limits and
// the coin changer state encoding.
package vend_pkg;

    // Coin values in 5-cent units; also used by the vending FSM's s0..s65 encoding.
    localparam int unsigned NICKEL_U  = 1;
    localparam int unsigned DIME_U    = 2;
    localparam int unsigned QUARTER_U = 5;

    // Largest change amount the changer pays out (65 cents).
    localparam int unsigned MAX_UNITS = 13;

    // Coin changer states.
    typedef enum logic [2:0] {
        CC_IDLE,
        CC_EJECT,
        CC_GAP,
        CC_DONE,
        CC_ERR
    } cc_state_t;

    // One-hot coin selection as presented to the ejector.
    typedef struct packed {
        logic quarter;
        logic dime;
        logic nickel;
    } coin_sel_t;

endpackage

// File: rtl/coin_changer_greedy_sel.sv
// Greedy coin chooser: picks the largest coin that does not exceed the
// balance still owed, and reports its value in 5-cent units.
module coin_greedy_sel
    import vend_pkg::*;
#(
    parameter int unsigned UNIT_W = 4
) (
    input  logic [UNIT_W-1:0] i_remaining,
    output coin_sel_t         o_sel,
    output logic [UNIT_W-1:0] o_value
);

    // Largest-coin-first selection; falls through to a nickel.
    always_comb begin
        o_sel   = '0;
        o_value = '0;
        if (i_remaining >= UNIT_W'(QUARTER_U)) begin
            o_sel.quarter = 1'b1;
            o_value       = UNIT_W'(QUARTER_U);
        end else if (i_remaining >= UNIT_W'(DIME_U)) begin
            o_sel.dime = 1'b1;
            o_value    = UNIT_W'(DIME_U);
        end else begin
            o_sel.nickel = 1'b1;
            o_value      = UNIT_W'(NICKEL_U);
        end
    end

endmodule

// File: rtl/coin_changer.sv
// Change-return dispenser: breaks a change amount into quarters, dimes and
// nickels and hands them to the ejector one at a time over valid/ready,
// leaving a settle gap after every accepted coin.
module coin_changer
    import vend_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned UNIT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [UNIT_W-1:0] amount,
    input  logic              coin_ready,
    output logic              eject_quarter,
    output logic              eject_dime,
    output logic              eject_nickel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [UNIT_W-1:0] remaining
);

    localparam int unsigned    GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    cc_state_t         r_state;
    cc_state_t         w_state_nxt;
    logic [UNIT_W-1:0] r_remaining;
    logic [UNIT_W-1:0] w_remaining_nxt;
    logic [GW-1:0]     r_gap_cnt;
    logic [GW-1:0]     w_gap_cnt_nxt;
    coin_sel_t         w_sel;
    logic [UNIT_W-1:0] w_coin_val;
    logic [UNIT_W-1:0] w_rem_after;

    coin_greedy_sel #(
        .UNIT_W (UNIT_W)
    ) u_greedy_sel (
        .i_remaining (r_remaining),
        .o_sel       (w_sel),
        .o_value     (w_coin_val)
    );

    // Greedy choice never exceeds the balance, so this cannot underflow.
    assign w_rem_after = r_remaining - w_coin_val;

    // State, balance and gap counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CC_IDLE;
            r_remaining <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
        end
    end

    // Next-state, balance and gap-counter logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_gap_cnt_nxt   = r_gap_cnt;
        case (r_state)
            CC_IDLE: begin
                if (start) begin
                    if (amount == '0) begin
                        w_state_nxt = CC_DONE;
                    end else if (32'(amount) > MAX_UNITS) begin
                        w_state_nxt = CC_ERR;
                    end else begin
                        w_remaining_nxt = amount;
                        w_state_nxt     = CC_EJECT;
                    end
                end
            end
            CC_EJECT: begin
                if (coin_ready) begin
                    w_remaining_nxt = w_rem_after;
                    if (w_rem_after == '0) begin
                        w_state_nxt = CC_DONE;
                    end else if (GAP_CYCLES > 0) begin
                        w_state_nxt   = CC_GAP;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end
                end
            end
            CC_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = CC_EJECT;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            CC_DONE: w_state_nxt = CC_IDLE;
            CC_ERR:  w_state_nxt = CC_IDLE;
            default: w_state_nxt = CC_IDLE;
        endcase
    end

    // Outputs decode from registered state and balance only.
    assign eject_quarter = (r_state == CC_EJECT) && w_sel.quarter;
    assign eject_dime    = (r_state == CC_EJECT) && w_sel.dime;
    assign eject_nickel  = (r_state == CC_EJECT) && w_sel.nickel;
    assign busy          = (r_state != CC_IDLE);
    assign done          = (r_state == CC_DONE);
    assign err           = (r_state == CC_ERR);
    assign remaining     = r_remaining;

endmodule

// File: tb/tb_coin_changer.sv
// Scoreboard bench for coin_changer: expected coin/done/err events are queued
// when a payout is requested and matched against what the ejector side sees.
module tb_coin_changer;
    import vend_pkg::*;

    localparam int EV_Q    = 1;
    localparam int EV_D    = 2;
    localparam int EV_N    = 3;
    localparam int EV_DONE = 4;
    localparam int EV_ERR  = 5;

    typedef struct {
        int kind;
        int rem;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] amount = '0;
    logic       coin_ready = 1'b0;
    logic       eject_quarter;
    logic       eject_dime;
    logic       eject_nickel;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] remaining;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  busy_cnt = 0;
    int  mdl_rem = 0;
    bit  mon_en = 1'b0;
    ev_t sb[$];
    int  hs_cyc[$];

    coin_changer #(
        .GAP_CYCLES (4),
        .UNIT_W     (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .amount        (amount),
        .coin_ready    (coin_ready),
        .eject_quarter (eject_quarter),
        .eject_dime    (eject_dime),
        .eject_nickel  (eject_nickel),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .remaining     (remaining)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observe the ejector side and pop the scoreboard on every event.
    always @(negedge clk) begin
        int  kind;
        ev_t ev;
        if (rst_n && mon_en) begin
            kind = 0;
            if (busy) busy_cnt++;
            check("exclusive", int'($countones({eject_quarter, eject_dime, eject_nickel, done, err}) <= 1), 1);
            if (coin_ready && eject_quarter)     kind = EV_Q;
            else if (coin_ready && eject_dime)   kind = EV_D;
            else if (coin_ready && eject_nickel) kind = EV_N;
            else if (done)                       kind = EV_DONE;
            else if (err)                        kind = EV_ERR;
            if (kind != 0) begin
                if (kind <= EV_N) hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_event", kind, 0);
                end else begin
                    ev = sb.pop_front();
                    check("event_kind", kind, ev.kind);
                    check("event_remaining", int'(remaining), ev.rem);
                end
            end
        end
    end

    // Queue expected events for a request, then present it for one edge.
    task automatic pay(input int a);
        int r;
        @(posedge clk);
        #1;
        if (a == 0) begin
            sb.push_back('{EV_DONE, mdl_rem});
        end else if (a > 13) begin
            sb.push_back('{EV_ERR, mdl_rem});
        end else begin
            r = a;
            while (r > 0) begin
                if (r >= 5)      begin sb.push_back('{EV_Q, r}); r -= 5; end
                else if (r >= 2) begin sb.push_back('{EV_D, r}); r -= 2; end
                else             begin sb.push_back('{EV_N, r}); r -= 1; end
            end
            sb.push_back('{EV_DONE, 0});
            mdl_rem = 0;
        end
        start  = 1'b1;
        amount = a[3:0];
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    // Request that the changer must ignore because it is busy.
    task automatic poke(input int a);
        @(posedge clk);
        #1;
        start  = 1'b1;
        amount = a[3:0];
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, int'(n < 400), 1);
        check({tag, "_drained"}, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int n;

        // Reset state
        #12;
        check("rst_outputs", int'({eject_quarter, eject_dime, eject_nickel, done, err, busy}), 0);
        check("rst_remaining", int'(remaining), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // 13 units, always ready: Q Q D N with 4-cycle gaps
        coin_ready = 1'b1;
        hs_cyc.delete();
        pay(13);
        wait_idle("pay13");
        check("pay13_coins", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) begin
            check("first_latency", hs_cyc[0] - start_cyc, 0);
            for (int i = 1; i < 4; i++) check("gap_spacing", hs_cyc[i] - hs_cyc[i-1], 5);
        end

        // 3 units with ejector stalled for 10 cycles
        coin_ready = 1'b0;
        pay(3);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (eject_dime && !eject_quarter && !eject_nickel && remaining == 4'd3) cnt++;
        end
        check("dime_hold", cnt, 10);
        @(posedge clk);
        #1 coin_ready = 1'b1;
        wait_idle("pay3");

        // Zero amount: done only, busy for one cycle
        busy_cnt = 0;
        hs_cyc.delete();
        pay(0);
        wait_idle("pay0");
        check("pay0_busy_cycles", busy_cnt, 1);
        check("pay0_coins", hs_cyc.size(), 0);

        // Out-of-range amounts
        pay(14);
        wait_idle("pay14");
        pay(15);
        wait_idle("pay15");
        check("err_remaining", int'(remaining), 0);

        // start during a payout is ignored
        hs_cyc.delete();
        pay(13);
        poke(2);
        repeat (3) @(negedge clk);
        poke(2);
        wait_idle("pay13_poked");
        check("poked_coins", hs_cyc.size(), 4);

        // Async reset after the first quarter
        hs_cyc.delete();
        pay(13);
        n = 0;
        while (hs_cyc.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_quarter_seen", hs_cyc.size(), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", int'({eject_quarter, eject_dime, eject_nickel, done, err, busy}), 0);
        check("midrst_remaining", int'(remaining), 0);
        sb.delete();
        mdl_rem = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("postrst_busy", int'(busy), 0);
        check("postrst_remaining", int'(remaining), 0);
        check("postrst_coins", hs_cyc.size(), 1);

        // Normal operation after reset
        pay(7);
        wait_idle("pay7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_changer.md
# coin_changer

Change-return dispenser for the vending machine: the back end of the coin path that pays coins out, where the vending FSM takes them in. It accepts a change amount in 5-cent units, breaks it into quarters, dimes and nickels (largest coin first), and drives a coin-ejector mechanism one coin at a time over a valid/ready handshake. It sits between the vending FSM's `Change` decision and the physical ejector solenoids.

## Interface
Clocking and reset (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.

Parameters:
- `GAP_CYCLES`, default 4: idle cycles inserted after each accepted coin so the ejector can settle; 0 is legal.
- `UNIT_W`, default 4: width of amount fields in 5-cent units.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  async active-low reset.
- `start`  in  1  request to pay out `amount`; sampled in IDLE only.
- `amount`  in  UNIT_W  change in 5-cent units; legal range 0..13 (0..65 cents).
- `coin_ready`  in  1  ejector accepts the presented coin this cycle.
- `eject_quarter`  out  1  valid: present a 25-cent coin.
- `eject_dime`  out  1  valid: present a 10-cent coin.
- `eject_nickel`  out  1  valid: present a 5-cent coin.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when payout completes.
- `err`  out  1  one-cycle pulse when `amount` > 13; no coins are issued.
- `remaining`  out  UNIT_W  registered balance still owed, in units (debug).

## Operation
- States: IDLE, EJECT, GAP, DONE, ERR.
- IDLE, `start`=1:
  - `amount`=0 → DONE.
  - `amount`>13 → ERR, `remaining` unchanged.
  - Otherwise `remaining`←`amount`, → EJECT.
- IDLE, `start`=0: stay in IDLE.
- EJECT: exactly one `eject_*` is high, chosen greedily from `remaining`:
  - ≥5 → quarter
  - ≥2 → dime
  - otherwise nickel
- Outputs decode from registered state and `remaining` only; they must not depend combinationally on `coin_ready`.
- EJECT, `coin_ready`=1 (handshake): `remaining` decrements by the coin value (5/2/1).
  - New value 0 → DONE.
  - Else `GAP_CYCLES`>0 → GAP, with gap counter loaded to `GAP_CYCLES`-1.
  - Else stay in EJECT with the next coin.
- EJECT, `coin_ready`=0: hold the state, `remaining`, and the same `eject_*` high indefinitely.
- GAP: all `eject_*` low; count down, and on 0 → EJECT.
- DONE: `done`=1 for one cycle → IDLE.
- ERR: `err`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored; `amount` is sampled only on the accepting edge.
- At most one of `eject_*`, `done`, `err` is high in any cycle.

## Timing
- Reset (async assert, sync-released state): state IDLE; `remaining`=0; gap counter 0; all outputs 0.
- Reset mid-payout abandons the remaining coins. There is no resume.
- `start` sampled at edge k → first `eject_*` visible from edge k (registered state), i.e. one cycle latency.
- A coin transfers on any rising edge where `eject_*` and `coin_ready` are both high.
- The next coin's valid rises `GAP_CYCLES`+1 cycles after that edge, or 1 cycle if `GAP_CYCLES`=0 (back-to-back). If `GAP_CYCLES`=0 and `coin_ready` stays high, one coin transfers per cycle.
- `done` pulses in the cycle after the final handshake; `busy` drops the following cycle.
- `amount`=0: `done` in the cycle after `start`, no eject.
- `err`: pulses in the cycle after `start`.
- Arithmetic: unsigned UNIT_W. Subtraction never underflows because greedy selection guarantees coin ≤ `remaining`.

## Structure
- Shared package `vend_pkg`:
  - coin unit constants NICKEL_U=1, DIME_U=2, QUARTER_U=5
  - MAX_UNITS=13
  - state enum for this block
- The vending FSM reuses the same unit constants for its s0..s65 encoding.
- One sub-module is natural: `coin_greedy_sel`, purely combinational. It maps `remaining` to a one-hot coin select plus the coin value in units.
- All state lives in `coin_changer`.

## Test plan
- `amount`=13, `coin_ready`=1 always, `GAP_CYCLES`=4 → quarter, quarter, dime, nickel. Each is valid for one cycle, separated by 4 low cycles; `remaining` steps 13→8→3→1→0; `done` pulses once.
- `amount`=3 with `coin_ready` held low for 10 cycles, then high → `eject_dime` stays high all 10 cycles with `remaining`=3, then transfers; nickel follows; then `done`.
- `amount`=0 → `done` one cycle after `start`, no `eject_*`, `busy` high for exactly 1 cycle.
- `amount`=14 and `amount`=15 → `err` one-cycle pulse, no coins, `remaining` unchanged, back to IDLE.
- `start` re-asserted with `amount`=2 during a 13-unit payout → ignored; the original sequence completes unchanged.
- `rst_n` low asynchronously after the first quarter transfers → all outputs 0 immediately; after release, IDLE with `remaining`=0 and no further coins.
